// File: rtl/simon_ctrl_pkg.sv
// Shared types and sizing for the SIMON 32/64 decrypt sequencer.
package simon_ctrl_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int KEY_NIBBLES = 16;
    localparam int BLK_NIBBLES = 8;
    localparam int ROUNDS      = 32;

    localparam int NIB_CNT_W = $clog2(KEY_NIBBLES);
    localparam int RND_CNT_W = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        LOAD_CT  = 3'd2,
        RUN      = 3'd3,
        UNLOAD   = 3'd4
    } state_t;

endpackage

// File: rtl/simon_ctrl_cnt.sv
// Loadable up/down counter with a terminal-count compare flag.
// srst clears the count synchronously; load has priority over counting.
module simon_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count register: clear, load, step up/down, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (srst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= up ? (count_r + W'(1)) : (count_r - W'(1));
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == term);

endmodule

// File: rtl/simon_decrypt_ctrl.sv
// Sequencer for the nibble-serial SIMON 32/64 decrypt core: loads key and
// ciphertext over a valid/ready stream, runs the rounds, streams plaintext out.
// Optional feature macro: SIMON_CTRL_KEY_RETAIN_EN (skip key load on reuse_key
// when a complete key is already held in the core).
module simon_decrypt_ctrl
    import simon_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 reuse_key,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIBBLE_W-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NIBBLE_W-1:0]  out_data,
    output logic [NIBBLE_W-1:0]  core_din,
    output logic                 core_key_shift,
    output logic                 core_blk_shift,
    output logic                 core_round_en,
    output logic [RND_CNT_W-1:0] core_round_idx,
    output logic                 core_out_shift,
    input  logic [NIBBLE_W-1:0]  core_dout,
    output logic                 busy,
    output logic                 done
);

    state_t                 state_r, state_s;
    logic                   done_r, done_set_s;
    logic                   retain_s;
    logic                   nib_load_s, nib_en_s, nib_tc_s;
    logic [NIB_CNT_W-1:0]   nib_term_s, nib_cnt_unused_s;
    logic                   rnd_load_s, rnd_en_s, rnd_tc_s;
    logic [RND_CNT_W-1:0]   rnd_cnt_s;

    assign nib_term_s = (state_r == LOAD_KEY) ? NIB_CNT_W'(KEY_NIBBLES - 1)
                                              : NIB_CNT_W'(BLK_NIBBLES - 1);

    simon_ctrl_cnt #(.W(NIB_CNT_W)) u_nib_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (abort),
        .load     (nib_load_s),
        .load_val ({NIB_CNT_W{1'b0}}),
        .en       (nib_en_s),
        .up       (1'b1),
        .term     (nib_term_s),
        .count    (nib_cnt_unused_s),
        .tc       (nib_tc_s)
    );

    simon_ctrl_cnt #(.W(RND_CNT_W)) u_rnd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (abort),
        .load     (rnd_load_s),
        .load_val (RND_CNT_W'(ROUNDS - 1)),
        .en       (rnd_en_s),
        .up       (1'b0),
        .term     ({RND_CNT_W{1'b0}}),
        .count    (rnd_cnt_s),
        .tc       (rnd_tc_s)
    );

`ifdef SIMON_CTRL_KEY_RETAIN_EN
    logic key_valid_r;

    // Key validity: set once the last key nibble lands; an abort before the
    // ciphertext phase means the core key may be partial, so drop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_r <= 1'b0;
        end else if (abort && ((state_r == IDLE) || (state_r == LOAD_KEY))) begin
            key_valid_r <= 1'b0;
        end else if (!abort && (state_r == LOAD_KEY) && in_valid && nib_tc_s) begin
            key_valid_r <= 1'b1;
        end else begin
            key_valid_r <= key_valid_r;
        end
    end

    assign retain_s = reuse_key & key_valid_r;
`else
    logic unused_reuse_key_s;
    assign unused_reuse_key_s = reuse_key;
    assign retain_s           = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Done pulse lands in the first IDLE cycle after the final output nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_set_s;
        end
    end

    // Next-state, core strobes and stream handshakes; abort overrides all.
    always_comb begin
        state_s        = state_r;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_data       = {NIBBLE_W{1'b0}};
        core_din       = {NIBBLE_W{1'b0}};
        core_key_shift = 1'b0;
        core_blk_shift = 1'b0;
        core_round_en  = 1'b0;
        core_round_idx = {RND_CNT_W{1'b0}};
        core_out_shift = 1'b0;
        nib_load_s     = 1'b0;
        nib_en_s       = 1'b0;
        rnd_load_s     = 1'b0;
        rnd_en_s       = 1'b0;
        done_set_s     = 1'b0;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = retain_s ? LOAD_CT : LOAD_KEY;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD_KEY: begin
                    in_ready       = 1'b1;
                    core_din       = in_data;
                    core_key_shift = in_valid;
                    if (in_valid && nib_tc_s) begin
                        nib_load_s = 1'b1;
                        state_s    = LOAD_CT;
                    end else begin
                        nib_en_s = in_valid;
                    end
                end
                LOAD_CT: begin
                    in_ready       = 1'b1;
                    core_din       = in_data;
                    core_blk_shift = in_valid;
                    if (in_valid && nib_tc_s) begin
                        nib_load_s = 1'b1;
                        rnd_load_s = 1'b1;
                        state_s    = RUN;
                    end else begin
                        nib_en_s = in_valid;
                    end
                end
                RUN: begin
                    core_round_en  = 1'b1;
                    core_round_idx = rnd_cnt_s;
                    if (rnd_tc_s) begin
                        state_s = UNLOAD;
                    end else begin
                        rnd_en_s = 1'b1;
                    end
                end
                UNLOAD: begin
                    out_valid      = 1'b1;
                    out_data       = core_dout;
                    core_out_shift = out_ready;
                    if (out_ready && nib_tc_s) begin
                        nib_load_s = 1'b1;
                        done_set_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        nib_en_s = out_ready;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != IDLE);
    assign done = done_r;

endmodule

// File: tb/tb_simon_decrypt_ctrl.sv
// Directed bench for simon_decrypt_ctrl. A stand-in for the SIMON core
// presents the known plaintext of the reference vector on core_dout.
module tb_simon_decrypt_ctrl;
    import simon_ctrl_pkg::*;

    localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] CT  = 32'hc69b_e9bb;
    localparam logic [31:0] PT  = 32'h6565_6877;
`ifdef SIMON_CTRL_KEY_RETAIN_EN
    localparam bit RETAIN = 1'b1;
`else
    localparam bit RETAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start, abort, reuse_key, in_valid, out_ready;
    logic [3:0] in_data;
    logic in_ready, out_valid, core_key_shift, core_blk_shift, core_round_en;
    logic core_out_shift, busy, done;
    logic [3:0] out_data, core_din, core_dout;
    logic [4:0] core_round_idx;

    int checks = 0;
    int errors = 0;

    simon_decrypt_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .reuse_key(reuse_key), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .core_din(core_din),
        .core_key_shift(core_key_shift), .core_blk_shift(core_blk_shift),
        .core_round_en(core_round_en), .core_round_idx(core_round_idx),
        .core_out_shift(core_out_shift), .core_dout(core_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Core stand-in: plaintext appears after the rounds, shifts per out strobe.
    logic [31:0] pt_sh = 32'h0;
    always @(posedge clk) begin
        if (core_round_en) pt_sh <= PT;
        else if (core_out_shift) pt_sh <= {pt_sh[27:0], 4'h0};
    end
    assign core_dout = pt_sh[31:28];

    // Strobe monitors (cumulative; the sequence works on deltas).
    int n_key = 0, n_blk = 0, n_rnd = 0, n_osh = 0, n_done = 0, idx_bad = 0;
    int cyc = 0, last_ct_cyc = 0, first_ov_cyc = 0;
    logic [63:0] key_cap = 64'h0;
    logic [31:0] ct_cap = 32'h0;
    logic [4:0]  exp_idx = 5'd31;
    logic        ov_q = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_key_shift) begin
            n_key   <= n_key + 1;
            key_cap <= {key_cap[59:0], core_din};
        end
        if (core_blk_shift) begin
            n_blk       <= n_blk + 1;
            ct_cap      <= {ct_cap[27:0], core_din};
            last_ct_cyc <= cyc;
            exp_idx     <= 5'd31;
        end else if (core_round_en) begin
            n_rnd <= n_rnd + 1;
            if (core_round_idx !== exp_idx) idx_bad <= idx_bad + 1;
            exp_idx <= exp_idx - 5'd1;
        end
        if (core_out_shift) n_osh <= n_osh + 1;
        if (done) n_done <= n_done + 1;
        if (out_valid && !ov_q) first_ov_cyc <= cyc;
        ov_q <= out_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] all_outs();
        return {in_ready, out_valid, out_data, core_din, core_key_shift, core_blk_shift,
                core_round_en, core_round_idx, core_out_shift, busy, done};
    endfunction

    task automatic push(input logic [3:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic do_start(input bit reuse);
        start = 1'b1;
        reuse_key = reuse;
        @(negedge clk);
        start = 1'b0;
        reuse_key = 1'b0;
    endtask

    // Key (optional) then ciphertext; in_valid is left high on return.
    task automatic load(input bit with_key, input int gap_at);
        logic [63:0] kv;
        logic [31:0] cv;
        int k0;
        kv = KEY;
        cv = CT;
        if (with_key) begin
            for (int i = 0; i < 16; i++) begin
                push(kv[4*(15-i) +: 4]);
                if (i == gap_at) begin
                    in_valid = 1'b0;
                    k0 = n_key;
                    repeat (3) @(negedge clk);
                    chk("gap_no_key_shift", 64'(n_key - k0), 64'd0);
                    chk("gap_in_ready", {63'd0, in_ready}, 64'd1);
                end
            end
        end
        for (int i = 0; i < 8; i++) push(cv[4*(7-i) +: 4]);
    endtask

    task automatic run_txn(input string tag, input bit reuse, input bit exp_key,
                           input int gap_at, input logic [3:0] pat);
        int k0, b0, r0, o0, d0, i0, got, t, k;
        bit stall;
        logic [3:0] held;
        logic [31:0] oc;
        k0 = n_key; b0 = n_blk; r0 = n_rnd; o0 = n_osh; d0 = n_done; i0 = idx_bad;
        do_start(reuse);
        load(exp_key, gap_at);
        // Now in RUN: in_valid stays high and start pulses; both must be ignored.
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        got = 0; t = 0; k = 0; stall = 1'b0; held = 4'h0; oc = 32'h0;
        while (got < 8 && t < 200) begin
            out_ready = pat[3 - (k % 4)];
            k++;
            if (out_valid) begin
                if (stall) chk({tag, "_hold"}, {60'd0, out_data}, {60'd0, held});
                if (out_ready) begin
                    oc = {oc[27:0], out_data};
                    got++;
                    stall = 1'b0;
                end else begin
                    held = out_data;
                    stall = 1'b1;
                end
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        chk({tag, "_done_hi"}, {62'd0, done, busy}, 64'd2);
        @(negedge clk);
        chk({tag, "_done_lo"}, {63'd0, done}, 64'd0);
        chk({tag, "_key_shifts"}, 64'(n_key - k0), exp_key ? 64'd16 : 64'd0);
        if (exp_key) chk({tag, "_key_data"}, key_cap, KEY);
        chk({tag, "_blk_shifts"}, 64'(n_blk - b0), 64'd8);
        chk({tag, "_ct_data"}, {32'd0, ct_cap}, {32'd0, CT});
        chk({tag, "_rounds"}, 64'(n_rnd - r0), 64'd32);
        chk({tag, "_round_idx"}, 64'(idx_bad - i0), 64'd0);
        chk({tag, "_latency"}, 64'(first_ov_cyc - last_ct_cyc), 64'd33);
        chk({tag, "_out_count"}, 64'(got), 64'd8);
        chk({tag, "_plaintext"}, {32'd0, oc}, {32'd0, PT});
        chk({tag, "_out_shifts"}, 64'(n_osh - o0), 64'd8);
        chk({tag, "_done_count"}, 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        int t, d0;
        start = 1'b0; abort = 1'b0; reuse_key = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = 4'h0;
        #1 rst_n = 1'b0;
        #1 chk("reset_outputs", {43'd0, all_outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {43'd0, all_outs()}, 64'd0);

        // Reference vector with an input gap and output backpressure 1,0,0,1.
        run_txn("vec", 1'b0, 1'b1, 5, 4'b1001);

        // Abort while the round index reads 10.
        do_start(1'b0);
        load(1'b1, -1);
        in_valid = 1'b0;
        t = 0;
        while (!(core_round_en && core_round_idx == 5'd10) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached_idx10", {59'd0, core_round_idx}, 64'd10);
        d0 = n_done;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {62'd0, busy, core_round_en}, 64'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_no_out_valid", {63'd0, out_valid}, 64'd0);

        // Abort and start together: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", {63'd0, busy}, 64'd0);

        run_txn("after_abort", 1'b0, 1'b1, -1, 4'b1111);
        run_txn("reuse", 1'b1, !RETAIN, -1, 4'b1111);

        // Asynchronous reset in the middle of UNLOAD.
        do_start(1'b0);
        load(1'b1, -1);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reached_unload", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", {43'd0, all_outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset no key is held, so reuse_key must still load the key.
        run_txn("post_reset", 1'b1, 1'b1, -1, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
